float_operand_feeder: RTL and testbench

FLOAT_OPERAND_FEEDER -- requirements
Module: float_operand_feeder

---
 rtl/float_adder_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 74 +++++++
 rtl/float_operand_feeder.sv | 71 +++++++
 tb/tb_float_operand_feeder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/float_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | float_adder_pkg: float32 and operand-pair types for the adder path   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package float_adder_pkg;

   localparam int DEPTH_DEFAULT = 4;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exponent;
      logic [22:0] fraction;
   } float32_t;

   typedef struct packed {
      float32_t a;
      float32_t b;
   } operand_pair_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo: single-clock FIFO, zero data output when empty            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         data_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [LW-1:0]    level_q, level_d;
   logic             w_push, w_pop;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign w_push  = push_i & ~full_o & ~flush_i;
   assign w_pop   = pop_i & ~empty_o & ~flush_i;
   assign data_o  = empty_o ? '0 : mem_q[rd_q];

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      level_d = level_q;
      if (flush_i) begin
         wr_d    = '0;
         rd_d    = '0;
         level_d = '0;
      end else begin
         if (w_push) wr_d = wr_q + AW'(1);
         if (w_pop)  rd_d = rd_q + AW'(1);
         case ({w_push, w_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) mem_q[wr_q] <= data_i;
   end

endmodule
`default_nettype wire

// File: rtl/float_operand_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | float_operand_feeder: queues operand pairs and hands them to adder   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module float_operand_feeder
   import float_adder_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_valid_i,
   output logic                   push_ready_o,
   input  logic [31:0]            push_a_i,
   input  logic [31:0]            push_b_i,
   input  logic                   adder_free_i,
   output logic                   inp_rdy_o,
   output logic [31:0]            in_a_o,
   output logic [31:0]            in_b_o,
   input  logic                   flush_i,
   output logic [$clog2(DEPTH):0] level_o,
   output logic [15:0]            issued_cnt_o
);
   operand_pair_t w_push_pair;
   operand_pair_t w_head_pair;
   logic          w_full;
   logic          w_empty;
   logic          w_handoff;
   logic [15:0]   issued_cnt_q, issued_cnt_d;

   assign w_push_pair = '{a: float32_t'(push_a_i), b: float32_t'(push_b_i)};

   sync_fifo #(
      .WIDTH ($bits(operand_pair_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (push_valid_i),
      .pop_i   (w_handoff),
      .data_i  (w_push_pair),
      .data_o  (w_head_pair),
      .level_o (level_o),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   assign push_ready_o = ~w_full;
   assign inp_rdy_o    = ~w_empty;
   assign in_a_o       = w_head_pair.a;
   assign in_b_o       = w_head_pair.b;

   // A flush on the same edge cancels the handoff so the adder never sees it counted.
   assign w_handoff = inp_rdy_o & adder_free_i & ~flush_i;

   always_comb begin
      issued_cnt_d = issued_cnt_q;
      if (w_handoff) issued_cnt_d = issued_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) issued_cnt_q <= '0;
      else         issued_cnt_q <= issued_cnt_d;
   end

   assign issued_cnt_o = issued_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_float_operand_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_float_operand_feeder: random + directed checks against a queue    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_float_operand_feeder;
   localparam int DEPTH = 4;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        push_valid_i = 1'b0;
   logic        push_ready_o;
   logic [31:0] push_a_i = '0;
   logic [31:0] push_b_i = '0;
   logic        adder_free_i = 1'b0;
   logic        inp_rdy_o;
   logic [31:0] in_a_o;
   logic [31:0] in_b_o;
   logic        flush_i = 1'b0;
   logic [$clog2(DEPTH):0] level_o;
   logic [15:0] issued_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] m_q[$];
   logic [15:0] m_cnt = '0;

   float_operand_feeder #(.DEPTH(DEPTH)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_valid_i (push_valid_i),
      .push_ready_o (push_ready_o),
      .push_a_i     (push_a_i),
      .push_b_i     (push_b_i),
      .adder_free_i (adder_free_i),
      .inp_rdy_o    (inp_rdy_o),
      .in_a_o       (in_a_o),
      .in_b_o       (in_b_o),
      .flush_i      (flush_i),
      .level_o      (level_o),
      .issued_cnt_o (issued_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [63:0] head;
      head = (m_q.size() != 0) ? m_q[0] : 64'd0;
      check_eq("level", 64'(level_o), 64'(m_q.size()));
      check_eq("push_ready", 64'(push_ready_o), 64'(m_q.size() != DEPTH));
      check_eq("inp_rdy", 64'(inp_rdy_o), 64'(m_q.size() != 0));
      check_eq("in_a", 64'(in_a_o), 64'(head[63:32]));
      check_eq("in_b", 64'(in_b_o), 64'(head[31:0]));
      check_eq("issued_cnt", 64'(issued_cnt_o), 64'(m_cnt));
   endtask

   // One clock: drive inputs, advance the queue model by the rules, then check.
   task automatic cycle(input logic pv, input logic [31:0] a, input logic [31:0] b,
                        input logic af, input logic fl);
      logic can_hand, can_push;
      push_valid_i = pv;
      push_a_i     = a;
      push_b_i     = b;
      adder_free_i = af;
      flush_i      = fl;
      can_hand = (m_q.size() != 0) && af;
      can_push = pv && (m_q.size() != DEPTH);
      @(posedge clk_i);
      if (fl) begin
         m_q.delete();
      end else begin
         if (can_hand) begin
            void'(m_q.pop_front());
            m_cnt = m_cnt + 16'd1;
         end
         if (can_push) m_q.push_back({a, b});
      end
      #1;
      check_all();
   endtask

   task automatic do_reset();
      #2;
      rst_ni       = 1'b0;
      push_valid_i = 1'b0;
      adder_free_i = 1'b1;
      flush_i      = 1'b0;
      #1;
      m_q.delete();
      m_cnt = '0;
      check_all();
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   initial begin
      logic [15:0] saved_cnt;
      int guard;

      #3;
      m_q.delete();
      check_all();
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Single pair: one-cycle latency then handoff.
      cycle(1'b1, 32'h3F800000, 32'h40000000, 1'b1, 1'b0);
      check_eq("r31_a", 64'(in_a_o), 64'h3F800000);
      check_eq("r31_b", 64'(in_b_o), 64'h40000000);
      check_eq("r31_rdy", 64'(inp_rdy_o), 64'd1);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check_eq("r31_cnt", 64'(issued_cnt_o), 64'd1);
      check_eq("r31_level", 64'(level_o), 64'd0);

      // Fill past full with adder stalled.
      for (int i = 0; i < 5; i++)
         cycle(1'b1, 32'h1000 + 32'(i), 32'h2000 + 32'(i), 1'b0, 1'b0);
      check_eq("r32_level", 64'(level_o), 64'd4);
      check_eq("r32_ready", 64'(push_ready_o), 64'd0);
      check_eq("r32_head", 64'(in_a_o), 64'h1000);

      // Full with push and handoff on same edge: pop only.
      cycle(1'b1, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0);
      check_eq("r33_level", 64'(level_o), 64'd3);
      check_eq("r33_ready", 64'(push_ready_o), 64'd1);
      check_eq("r33_head", 64'(in_a_o), 64'h1001);

      // Level 2 steady state with pointer wrap.
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++)
         cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0);
      check_eq("r34_level", 64'(level_o), 64'd2);

      // Flush at level 3 overrides handoff.
      cycle(1'b1, 32'h3000, 32'h4000, 1'b0, 1'b0);
      saved_cnt = m_cnt;
      cycle(1'b1, 32'h5000, 32'h6000, 1'b1, 1'b1);
      check_eq("r35_level", 64'(level_o), 64'd0);
      check_eq("r35_rdy", 64'(inp_rdy_o), 64'd0);
      check_eq("r35_cnt", 64'(issued_cnt_o), 64'(saved_cnt));

      // Randomised traffic.
      for (int i = 0; i < 400; i++)
         cycle(($urandom % 4) != 0, $urandom, $urandom, $urandom % 2,
               ($urandom % 32) == 0);

      // Mid-stream asynchronous reset.
      do_reset();
      check_eq("rst_level", 64'(level_o), 64'd0);

      // Drive the issue counter through its wrap.
      guard = 0;
      while (m_cnt != 16'hFFFF && guard < 70000) begin
         cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0);
         guard++;
      end
      check_eq("wrap_reach", 64'(issued_cnt_o), 64'hFFFF);
      cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0);
      check_eq("wrap_zero", 64'(issued_cnt_o), 64'd0);
      cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0);

      do_reset();
      check_eq("rst2_cnt", 64'(issued_cnt_o), 64'd0);
      check_eq("rst2_a", 64'(in_a_o), 64'd0);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
